// File: rtl/laundry_scheduler_pkg.sv
// Shared types and helpers for the laundry scheduler: machine states, wash type codes
// and the wash-type to duration mapping.
package laundry_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mstate_e;

  typedef enum logic [1:0] {
    TYPE_NONE   = 2'd0,
    TYPE_QUICK  = 2'd1,
    TYPE_NORMAL = 2'd2,
    TYPE_HEAVY  = 2'd3
  } wash_type_e;

  // Returns 0 for TYPE_NONE; such requests are rejected before the value is used.
  function automatic int unsigned wash_duration(input logic [1:0] wtype,
                                                input int unsigned t_quick,
                                                input int unsigned t_normal,
                                                input int unsigned t_heavy);
    int unsigned d;
    case (wtype)
      TYPE_QUICK:  d = t_quick;
      TYPE_NORMAL: d = t_normal;
      TYPE_HEAVY:  d = t_heavy;
      default:     d = 32'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/laundry_scheduler_machine_timer.sv
// One washing machine: FREE/RUN/FINISH state machine with a countdown of remaining ticks.
module machine_timer
  import laundry_pkg::*;
#(
  parameter int TIME_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              load,
  input  logic [TIME_W-1:0] load_time,
  input  logic              abort,
  input  logic              collect,
  output logic              busy,
  output logic              finished,
  output logic              done,
  output logic [TIME_W-1:0] time_left
);

  mstate_e           state_r;
  logic [TIME_W-1:0] timer_r;

  assign time_left = timer_r;

  // State, countdown and registered status flags; abort outranks a same-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= FREE;
      timer_r  <= {TIME_W{1'b0}};
      busy     <= 1'b0;
      finished <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        FREE: begin
          if (load) begin
            state_r  <= RUN;
            timer_r  <= load_time;
            busy     <= 1'b1;
            finished <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state_r <= FREE;
            timer_r <= {TIME_W{1'b0}};
            busy    <= 1'b0;
          end else if (tick) begin
            // Compare with <= so a zero count can never wrap around.
            if (timer_r <= TIME_W'(1)) begin
              state_r  <= FINISH;
              timer_r  <= {TIME_W{1'b0}};
              finished <= 1'b1;
              done     <= 1'b1;
            end else begin
              timer_r <= timer_r - TIME_W'(1);
            end
          end
        end
        FINISH: begin
          if (collect) begin
            state_r  <= FREE;
            busy     <= 1'b0;
            finished <= 1'b0;
          end
        end
        default: begin
          state_r  <= FREE;
          timer_r  <= {TIME_W{1'b0}};
          busy     <= 1'b0;
          finished <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/laundry_scheduler.sv
// Laundry scheduler top: request arbitration with round-robin "any machine" pick,
// four machine timers and the remaining-time display mux.
module laundry_scheduler
  import laundry_pkg::*;
#(
  parameter int N_MACHINES = 4,
  parameter int TIME_W     = 8,
  parameter int T_QUICK    = 20,
  parameter int T_NORMAL   = 40,
  parameter int T_HEAVY    = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  req_valid,
  input  logic                  req_any,
  input  logic [1:0]            req_id,
  input  logic [1:0]            req_type,
  output logic                  grant,
  output logic [1:0]            grant_id,
  output logic                  reject,
  input  logic                  collect,
  input  logic [1:0]            collect_id,
  input  logic                  abort,
  input  logic [1:0]            abort_id,
  output logic [N_MACHINES-1:0] busy,
  output logic [N_MACHINES-1:0] finished,
  output logic [N_MACHINES-1:0] done,
  input  logic [1:0]            disp_id,
  output logic [TIME_W-1:0]     disp_time
);

  logic [1:0]            rr_ptr_r;
  logic [N_MACHINES-1:0] free_s;
  logic [N_MACHINES-1:0] load_s;
  logic [TIME_W-1:0]     load_time_s;
  logic [TIME_W-1:0]     time_s [N_MACHINES];
  logic                  found_s;
  logic [1:0]            pick_s;
  logic                  accept_s;
  logic [1:0]            target_s;

  // Decisions use the registered state only, so same-cycle abort/collect do not free a machine.
  assign free_s      = ~busy;
  assign load_s      = accept_s ? ({{(N_MACHINES-1){1'b0}}, 1'b1} << target_s) : {N_MACHINES{1'b0}};
  assign load_time_s = TIME_W'(wash_duration(req_type, T_QUICK, T_NORMAL, T_HEAVY));
  assign disp_time   = busy[disp_id] ? time_s[disp_id] : {TIME_W{1'b0}};

  // Round-robin search for the first FREE machine starting at the pointer.
  always_comb begin
    found_s = 1'b0;
    pick_s  = rr_ptr_r;
    for (int k = 0; k < N_MACHINES; k++) begin
      if (!found_s && free_s[rr_ptr_r + 2'(k)]) begin
        found_s = 1'b1;
        pick_s  = rr_ptr_r + 2'(k);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Accept/refuse the incoming request and choose its target machine.
  always_comb begin
    accept_s = 1'b0;
    target_s = 2'd0;
    if (req_valid && (req_type != TYPE_NONE)) begin
      if (req_any) begin
        accept_s = found_s;
        target_s = pick_s;
      end else begin
        accept_s = free_s[req_id];
        target_s = req_id;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Registered grant/reject pulses and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant    <= 1'b0;
      grant_id <= 2'd0;
      reject   <= 1'b0;
      rr_ptr_r <= 2'd0;
    end else begin
      grant    <= accept_s;
      grant_id <= accept_s ? target_s : 2'd0;
      reject   <= req_valid && !accept_s;
      rr_ptr_r <= accept_s ? (target_s + 2'd1) : rr_ptr_r;
    end
  end

  for (genvar i = 0; i < N_MACHINES; i++) begin : g_machine
    machine_timer #(
      .TIME_W(TIME_W)
    ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .load     (load_s[i]),
      .load_time(load_time_s),
      .abort    (abort && (abort_id == 2'(i))),
      .collect  (collect && (collect_id == 2'(i))),
      .busy     (busy[i]),
      .finished (finished[i]),
      .done     (done[i]),
      .time_left(time_s[i])
    );
  end

endmodule

// File: doc/laundry_scheduler.md
Name: laundry_scheduler

Overview:
- Allocates and sequences the washing machines once a customer has paid and chosen a wash type.
- Accepts one request per cycle, either for a specific machine or "any free machine" (round-robin pick).
- Runs a per-machine countdown timer for the selected wash duration and holds each machine in FINISH until the clothes are collected.
- Sits between the payment/wash-selection FSMs (request source) and the display multiplexer (status and remaining-time sink).

Parameters:
- N_MACHINES, 4, number of machines; fixed at 4 in this design (id width 2).
- TIME_W, 8, width of the remaining-time counters, in ticks.
- T_QUICK, 20, duration in ticks for wash type 1. Must be ≥1 and <2^TIME_W.
- T_NORMAL, 40, duration in ticks for wash type 2. Same range rule.
- T_HEAVY, 60, duration in ticks for wash type 3. Same range rule.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- tick, input, 1, one-cycle time-base enable (1 s pulse from the frequency divider).
- req_valid, input, 1, request strobe; sampled every cycle.
- req_any, input, 1, 1 = pick any free machine; 0 = use req_id.
- req_id, input, 2, requested machine when req_any=0.
- req_type, input, 2, wash type: 0 invalid, 1 quick, 2 normal, 3 heavy.
- grant, output, 1, one-cycle pulse: request accepted.
- grant_id, output, 2, machine granted; valid while grant=1.
- reject, output, 1, one-cycle pulse: request refused.
- collect, input, 1, customer-collected strobe.
- collect_id, input, 2, machine being collected.
- abort, input, 1, operator cancel strobe.
- abort_id, input, 2, machine being cancelled.
- busy, output, 4, per machine: 1 = RUN or FINISH.
- finished, output, 4, per machine: 1 = FINISH.
- done, output, 4, one-cycle pulse per machine on RUN->FINISH.
- disp_id, input, 2, machine selected for display.
- disp_time, output, TIME_W, remaining ticks of machine disp_id.

Behaviour:
- Reset state: all machines FREE with timers 0, round-robin pointer 0, and every output 0.
- Per-machine FSM:
  - FREE -> RUN on grant to that machine; the timer loads the duration for req_type.
  - RUN: timer decrements by 1 on each tick.
  - RUN -> FINISH on a tick while timer==1; timer becomes 0 and done[i] pulses in the same cycle as the state change.
  - RUN -> FREE on abort with abort_id==i; timer is cleared and no done pulse is generated.
  - FINISH -> FREE on collect with collect_id==i.
  - collect aimed at a non-FINISH machine is ignored. abort aimed at a non-RUN machine is ignored.
- Request handling:
  - Evaluated against the registered state at the start of the cycle.
  - grant or reject is registered and appears 1 cycle after req_valid.
  - Exactly one of grant/reject pulses per accepted-for-evaluation request.
  - Rejected when req_type==0, when req_any=0 and machine req_id is not FREE, or when req_any=1 and no machine is FREE.
- Round-robin pick: search starts at the pointer and takes the first FREE index, wrapping 3->0. After any grant the pointer becomes grant_id+1 mod 4. A direct request (req_any=0) also advances the pointer.
- Same-cycle events:
  - A machine granted in a cycle where tick=1 loads the full duration and does not decrement that cycle.
  - An abort or collect in the same cycle as a request: the request still sees the old state, so that machine counts as not FREE.
  - abort, collect, tick and grant on different machines in one cycle are all applied independently.
- Status outputs:
  - busy and finished are registered state decodes.
  - disp_time is combinational from the registered timer selected by disp_id; 0 for a FREE machine.
- Timers never underflow; a tick while in FINISH or FREE has no effect.
- A reset asserted mid-run forces every machine to FREE immediately on the next edge, with no done pulses.

Decomposition:
- Package laundry_pkg holds:
  - machine state encoding: FREE, RUN, FINISH;
  - wash type codes: TYPE_NONE, TYPE_QUICK, TYPE_NORMAL, TYPE_HEAVY;
  - a function that maps a type to its duration using the parameters.
- Sub-module machine_timer (one FSM plus countdown counter), instantiated 4 times.
- The top level contains the request arbiter, the round-robin pointer and the display mux.

Test Plan:
- Reset, then req_any=1, type=1 -> next cycle grant=1, grant_id=0. busy=0001, disp_id=0 gives disp_time=20. After 20 ticks: done[0] pulses and finished=0001. collect_id=0 -> busy=0000.
- Two consecutive req_any requests, types 2 and 3 -> grant_id 0 then 1, with timers 40 and 60. A third direct request req_id=1 -> reject=1 and no state change.
- Machines 0–3 all RUN, then a req_any request -> reject. abort_id=2 -> busy=1011 with no done[2] pulse. Next req_any request -> grant_id=2.
- Grant issued in the same cycle as tick=1 -> timer reads T_QUICK, not T_QUICK-1, and the first decrement happens on the next tick.
- req_type=0 with req_any=1 while everything is FREE -> reject, pointer unchanged.
- Reset asserted with machine 1 at remaining time 7 -> next cycle busy=0000, finished=0000, disp_time=0, and no done pulse.
